reg_file_wb: RTL and testbench

LC-3 general-purpose register file with its write-back (destination) side: an internal DR select, a valid/ready write port, and a sequenced scrub that zeroes all registers. It pairs with the SR1/SR2 read-address selection in the datapath: those select which register is read, and this block decides which register is written and when. It sits between the datapath bus and the ALU operand inputs.

---
 rtl/reg_file_wb.sv | 95 +++++++++
 tb/tb_reg_file_wb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// LC-3 register file with write-back port (DR select, valid/ready write) and a sequenced scrub.
// Optional same-cycle write-to-read forwarding is enabled by defining WB_BYPASS_EN.
module reg_file_wb #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [2:0]       IR_11_9,
  input  logic             DRMUX_select,
  input  logic             Wr_Valid,
  output logic             Wr_Ready,
  input  logic [WIDTH-1:0] Wr_Data,
  input  logic [2:0]       SR1,
  input  logic [2:0]       SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  input  logic             Scrub,
  output logic             Busy,
  output logic [2:0]       DR_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCRUB = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_cnt;
  logic [2:0]       r_dr_last;
  logic [WIDTH-1:0] r_regs [NREGS];

  logic [2:0]       w_dr;
  logic             w_commit;
  logic             w_scrub_last;

  // R7 is the JSR/TRAP link register.
  assign w_dr         = DRMUX_select ? 3'b111 : IR_11_9;
  assign w_commit     = Wr_Valid && Wr_Ready;
  assign w_scrub_last = (r_cnt == 3'd7);

  assign Wr_Ready = (r_state == S_IDLE);
  assign Busy     = (r_state == S_SCRUB);
  assign DR_last  = r_dr_last;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (Scrub) w_next_state = S_SCRUB;
      S_SCRUB: if (w_scrub_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_dr_last <= 3'd0;
    end else begin
      r_state <= w_next_state;
      // Scrub requests outside IDLE are ignored, so the count never restarts mid-scrub.
      if (r_state == S_IDLE && Scrub)
        r_cnt <= 3'd0;
      else if (r_state == S_SCRUB)
        r_cnt <= r_cnt + 3'd1;
      if (w_commit)
        r_dr_last <= w_dr;
    end
  end

  // Writes only commit in IDLE, so the scrub clear and the write port never collide.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (r_state == S_SCRUB) begin
      r_regs[r_cnt] <= '0;
    end else if (w_commit) begin
      r_regs[w_dr] <= Wr_Data;
    end
  end

`ifdef WB_BYPASS_EN
  assign SR1_OUT = (w_commit && (w_dr == SR1)) ? Wr_Data : r_regs[SR1];
  assign SR2_OUT = (w_commit && (w_dr == SR2)) ? Wr_Data : r_regs[SR2];
`else
  assign SR1_OUT = r_regs[SR1];
  assign SR2_OUT = r_regs[SR2];
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb against a behavioural register-file model.
module tb_reg_file_wb;

  logic        Clk;
  logic        Reset;
  logic [2:0]  IR_11_9;
  logic        DRMUX_select;
  logic        Wr_Valid;
  logic        Wr_Ready;
  logic [15:0] Wr_Data;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_OUT;
  logic        Scrub;
  logic        Busy;
  logic [2:0]  DR_last;

  int checks = 0;
  int errors = 0;

  // Model: register contents, last write address, and scrub progress (0 idle, 1 scrubbing, 2 done).
  logic [15:0] m_regs [8];
  logic [2:0]  m_dr_last;
  int          m_mode;
  int          m_k;

  reg_file_wb #(.WIDTH(16), .NREGS(8)) dut (
    .Clk(Clk), .Reset(Reset), .IR_11_9(IR_11_9), .DRMUX_select(DRMUX_select),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
    .SR1(SR1), .SR2(SR2), .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT),
    .Scrub(Scrub), .Busy(Busy), .DR_last(DR_last)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  function automatic logic [2:0] dr_of();
    return DRMUX_select ? 3'd7 : IR_11_9;
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] a);
`ifdef WB_BYPASS_EN
    if (m_mode == 0 && Wr_Valid && dr_of() == a) return Wr_Data;
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_dr_last = 3'd0;
    m_mode = 0;
    m_k = 0;
  endtask

  task automatic tick();
    if (m_mode == 0) begin
      if (Wr_Valid) begin
        m_regs[dr_of()] = Wr_Data;
        m_dr_last = dr_of();
      end
      if (Scrub) begin
        m_mode = 1;
        m_k = 0;
      end
    end else if (m_mode == 1) begin
      m_regs[m_k] = 16'h0;
      m_k++;
      if (m_k == 8) m_mode = 2;
    end else begin
      m_mode = 0;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    DRMUX_select = 1'b0;
    IR_11_9 = a;
    Wr_Data = d;
    Wr_Valid = 1'b1;
    tick();
    Wr_Valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'($urandom));
    Reset = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      SR2 = 3'(7 - i);
      #1;
      checks++;
      if (SR1_OUT !== 16'h0 || SR2_OUT !== 16'h0) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h/%h want 0000/0000", i, SR1_OUT, SR2_OUT);
      end
    end
    checks++;
    if (Wr_Ready !== 1'b1 || Busy !== 1'b0 || DR_last !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b dr_last=%0d want 1 0 0", Wr_Ready, Busy, DR_last);
    end
    #2;
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_write();
    write_reg(3'd3, 16'h5555);
    IR_11_9 = 3'd3;
    DRMUX_select = 1'b0;
    Wr_Data = 16'hBEEF;
    Wr_Valid = 1'b1;
    SR1 = 3'd3;
    #1;
    checks++;
`ifdef WB_BYPASS_EN
    if (SR1_OUT !== 16'hBEEF) begin
`else
    if (SR1_OUT !== 16'h5555) begin
`endif
      errors++;
      $display("FAIL write_same_cycle: got %h want %h", SR1_OUT, exp_read(3'd3));
    end
    tick();
    Wr_Valid = 1'b0;
    #1;
    checks++;
    if (SR1_OUT !== 16'hBEEF || DR_last !== 3'd3) begin
      errors++;
      $display("FAIL write_next_cycle: got %h dr_last=%0d want beef 3", SR1_OUT, DR_last);
    end
  endtask

  task automatic test_drmux();
    write_reg(3'd2, 16'h2222);
    DRMUX_select = 1'b1;
    IR_11_9 = 3'd2;
    Wr_Data = 16'h3001;
    Wr_Valid = 1'b1;
    tick();
    Wr_Valid = 1'b0;
    DRMUX_select = 1'b0;
    SR1 = 3'd7;
    SR2 = 3'd2;
    #1;
    checks++;
    if (SR1_OUT !== 16'h3001 || SR2_OUT !== 16'h2222 || DR_last !== 3'd7) begin
      errors++;
      $display("FAIL drmux_r7: got r7=%h r2=%h dr_last=%0d want 3001 2222 7", SR1_OUT, SR2_OUT, DR_last);
    end
  endtask

  task automatic test_scrub();
    int busy_cnt = 0;
    int notready_cnt = 0;
    int guard = 0;
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(16'h1111 * i));
    Scrub = 1'b1;
    tick();
    Scrub = 1'b0;
    IR_11_9 = 3'd5;
    Wr_Data = 16'hAAAA;
    Wr_Valid = 1'b1;
    while (Wr_Ready !== 1'b1 && guard < 20) begin
      if (Busy === 1'b1) busy_cnt++;
      notready_cnt++;
      for (int j = 0; j < 8; j++) begin
        SR1 = 3'(j);
        SR2 = 3'(7 - j);
        #1;
        checks++;
        if (SR1_OUT !== exp_read(3'(j)) || SR2_OUT !== exp_read(3'(7 - j))) begin
          errors++;
          $display("FAIL scrub_read step%0d r%0d: got %h/%h want %h/%h", guard, j,
                   SR1_OUT, SR2_OUT, exp_read(3'(j)), exp_read(3'(7 - j)));
        end
      end
      Scrub = (guard == 3);
      tick();
      Scrub = 1'b0;
      guard++;
    end
    checks++;
    if (busy_cnt != 8 || notready_cnt != 9) begin
      errors++;
      $display("FAIL scrub_timing: got busy=%0d notready=%0d want 8 9", busy_cnt, notready_cnt);
    end
    tick();
    Wr_Valid = 1'b0;
    SR1 = 3'd5;
    SR2 = 3'd0;
    #1;
    checks++;
    if (SR1_OUT !== 16'hAAAA || SR2_OUT !== 16'h0 || DR_last !== 3'd5) begin
      errors++;
      $display("FAIL scrub_held_write: got r5=%h r0=%h dr_last=%0d want aaaa 0000 5", SR1_OUT, SR2_OUT, DR_last);
    end
  endtask

  task automatic test_write_and_scrub();
    IR_11_9 = 3'd4;
    DRMUX_select = 1'b0;
    Wr_Data = 16'h1234;
    Wr_Valid = 1'b1;
    Scrub = 1'b1;
    tick();
    Wr_Valid = 1'b0;
    Scrub = 1'b0;
    SR1 = 3'd4;
    #1;
    checks++;
    if (SR1_OUT !== 16'h1234 || Busy !== 1'b1 || DR_last !== 3'd4) begin
      errors++;
      $display("FAIL wr_scrub_commit: got %h busy=%b dr_last=%0d want 1234 1 4", SR1_OUT, Busy, DR_last);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (SR1_OUT !== 16'h0 || Wr_Ready !== 1'b1 || DR_last !== 3'd4) begin
      errors++;
      $display("FAIL wr_scrub_cleared: got %h ready=%b dr_last=%0d want 0000 1 4", SR1_OUT, Wr_Ready, DR_last);
    end
  endtask

  task automatic test_reset_mid_scrub();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'($urandom) | 16'h1);
    Scrub = 1'b1;
    tick();
    Scrub = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    Reset = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      SR2 = 3'(i);
      #1;
      checks++;
      if (SR1_OUT !== 16'h0 || SR2_OUT !== 16'h0) begin
        errors++;
        $display("FAIL midscrub_reset_read r%0d: got %h/%h want 0000/0000", i, SR1_OUT, SR2_OUT);
      end
    end
    #2;
    Reset = 1'b1;
    tick();
    checks++;
    if (Wr_Ready !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL midscrub_reset_ctrl: got ready=%b busy=%b want 1 0", Wr_Ready, Busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      IR_11_9 = 3'($urandom);
      DRMUX_select = ($urandom_range(0, 3) == 0);
      Wr_Data = 16'($urandom);
      Wr_Valid = ($urandom_range(0, 1) == 1);
      Scrub = ($urandom_range(0, 15) == 0);
      SR1 = 3'($urandom);
      SR2 = 3'($urandom);
      #1;
      checks++;
      if (SR1_OUT !== exp_read(SR1) || SR2_OUT !== exp_read(SR2) ||
          Wr_Ready !== (m_mode == 0) || Busy !== (m_mode == 1) || DR_last !== m_dr_last) begin
        errors++;
        $display("FAIL random c%0d: got sr1=%h sr2=%h rdy=%b busy=%b drl=%0d want %h %h %b %b %0d",
                 c, SR1_OUT, SR2_OUT, Wr_Ready, Busy, DR_last, exp_read(SR1), exp_read(SR2),
                 (m_mode == 0), (m_mode == 1), m_dr_last);
      end
      tick();
    end
    Wr_Valid = 1'b0;
    Scrub = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    IR_11_9 = 3'd0;
    DRMUX_select = 1'b0;
    Wr_Valid = 1'b0;
    Wr_Data = 16'h0;
    SR1 = 3'd0;
    SR2 = 3'd0;
    Scrub = 1'b0;
    model_reset();
    #15;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    test_reset();
    test_write();
    test_drmux();
    test_scrub();
    test_write_and_scrub();
    test_reset_mid_scrub();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
